// File: rtl/simplecpu_load_ctrl.sv
// Load/run sequencer for the simple CPU: streams a host program image into RAM,
// then releases the CPU and times its run until halt or watchdog expiry.
module simplecpu_load_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [CNT_W-1:0]  run_limit,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_rst,
  input  logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  run_cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FINISHED
  } state_t;

  localparam logic [ADDR_W:0]  LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]  LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W:0]     r_len;
  logic [CNT_W-1:0]    r_limit;
  logic [ADDR_W:0]     r_count;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic                r_done;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_run_cycles;

  logic                w_len_ok;
  logic                w_start_ok;
  logic                w_xfer;
  logic                w_last;
  logic                w_limit_hit;
  logic                w_in_ready;
  logic                w_busy;
  logic                w_cpu_rst;

  assign w_len_ok    = (load_len != '0) && (load_len <= LEN_MAX);
  assign w_start_ok  = start && w_len_ok && ((r_state == S_IDLE) || (r_state == S_FINISHED));
  assign w_xfer      = in_valid && (r_state == S_LOAD);
  assign w_last      = (r_count == (r_len - LEN_ONE));
  assign w_limit_hit = (r_limit != '0) && (r_run_cycles == (r_limit - CNT_ONE));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and the state-decoded outputs; halt is checked before the watchdog
  // so a halt in the limit cycle still counts as a normal finish.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_busy       = 1'b0;
    w_cpu_rst    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_xfer && w_last) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_busy    = 1'b1;
        w_cpu_rst = 1'b0;
        if (cpu_halt || w_limit_hit) begin
          w_state_next = S_FINISHED;
        end
      end
      S_FINISHED: begin
        // Leave a normally halted CPU out of reset so its state can be inspected.
        w_cpu_rst = !r_done;
        if (w_start_ok) begin
          w_state_next = S_LOAD;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_len        <= '0;
      r_limit      <= '0;
      r_count      <= '0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_run_cycles <= '0;
    end else begin
      r_ram_we <= 1'b0;
      if (w_start_ok) begin
        r_len        <= load_len;
        r_limit      <= run_limit;
        r_count      <= '0;
        r_done       <= 1'b0;
        r_timeout    <= 1'b0;
        r_run_cycles <= '0;
      end
      if (w_xfer) begin
        r_ram_we    <= 1'b1;
        r_ram_addr  <= r_count[ADDR_W-1:0];
        r_ram_wdata <= in_data;
        r_count     <= r_count + LEN_ONE;
      end
      if (r_state == S_RUN) begin
        if (cpu_halt) begin
          r_done <= 1'b1;
        end else begin
          // The expiring cycle is still counted, so run_cycles ends equal to the limit.
          if (r_run_cycles != CNT_MAX) begin
            r_run_cycles <= r_run_cycles + CNT_ONE;
          end
          if (w_limit_hit) begin
            r_timeout <= 1'b1;
          end
        end
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign busy       = w_busy;
  assign cpu_rst    = w_cpu_rst;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign run_cycles = r_run_cycles;

endmodule

// File: tb/tb_simplecpu_load_ctrl.sv
// Directed bench for simplecpu_load_ctrl: load, halt, watchdog, gapped input,
// ignored starts and asynchronous reset, with hand-computed expectations.
module tb_simplecpu_load_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic              wb_clk_i;
  logic              wb_rst_i;
  logic              start;
  logic [ADDR_W:0]   load_len;
  logic [CNT_W-1:0]  run_limit;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              cpu_rst;
  logic              cpu_halt;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CNT_W-1:0]  run_cycles;

  int checks;
  int failures;

  simplecpu_load_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .start     (start),
    .load_len  (load_len),
    .run_limit (run_limit),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .cpu_rst   (cpu_rst),
    .cpu_halt  (cpu_halt),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .run_cycles(run_cycles)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    wb_rst_i  = 1'b1;
    start     = 1'b0;
    load_len  = '0;
    run_limit = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    cpu_halt  = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_run_cycles", run_cycles, 0);
    wb_rst_i = 1'b0;

    // 1: four back-to-back words, then halt after 4 RUN cycles
    start = 1'b1; load_len = 4; run_limit = 0;
    tick();
    start = 1'b0;
    check("t1_load_in_ready", in_ready, 1);
    check("t1_load_busy", busy, 1);
    check("t1_load_cpu_rst", cpu_rst, 1);
    check("t1_load_no_we", ram_we, 0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h11 * (i + 1));
      tick();
      check("t1_we", ram_we, 1);
      check("t1_addr", ram_addr, i);
      check("t1_data", ram_wdata, 32'(8'h11 * (i + 1)));
    end
    in_valid = 1'b0;
    check("t1_ready_drop", in_ready, 0);
    check("t1_cpu_rst_run", cpu_rst, 0);
    check("t1_rc0", run_cycles, 0);
    tick();
    check("t1_we_pulse", ram_we, 0);
    check("t1_rc1", run_cycles, 1);
    repeat (3) tick();
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    check("t1_done", done, 1);
    check("t1_timeout", timeout, 0);
    check("t1_rc", run_cycles, 4);
    check("t1_cpu_rst", cpu_rst, 0);
    check("t1_busy", busy, 0);

    // 2: sixteen words, halt 37 cycles after RUN entry
    start = 1'b1; load_len = 16; run_limit = 0;
    tick();
    start = 1'b0;
    check("t2_cpu_rst_restart", cpu_rst, 1);
    check("t2_done_clr", done, 0);
    check("t2_rc_clr", run_cycles, 0);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hA0 + i);
      tick();
      check("t2_we", ram_we, 1);
      check("t2_addr", ram_addr, i);
      check("t2_data", ram_wdata, 32'(8'hA0 + i));
    end
    in_valid = 1'b0;
    repeat (37) tick();
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    check("t2_done", done, 1);
    check("t2_timeout", timeout, 0);
    check("t2_rc", run_cycles, 37);
    check("t2_cpu_rst", cpu_rst, 0);
    check("t2_busy", busy, 0);
    repeat (3) tick();
    check("t2_rc_frozen", run_cycles, 37);

    // 3: watchdog of 10 cycles, no halt
    start = 1'b1; load_len = 1; run_limit = 10;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    check("t3_we", ram_we, 1);
    check("t3_addr", ram_addr, 0);
    check("t3_data", ram_wdata, 8'h5A);
    check("t3_cpu_rst_run", cpu_rst, 0);
    repeat (9) tick();
    check("t3_pre_timeout", timeout, 0);
    check("t3_pre_busy", busy, 1);
    check("t3_pre_rc", run_cycles, 9);
    tick();
    check("t3_timeout", timeout, 1);
    check("t3_done", done, 0);
    check("t3_rc", run_cycles, 10);
    check("t3_cpu_rst", cpu_rst, 1);
    check("t3_busy", busy, 0);

    // 4: halt in the 10th RUN cycle beats the watchdog
    start = 1'b1; load_len = 1; run_limit = 10;
    tick();
    start = 1'b0;
    check("t4_timeout_clr", timeout, 0);
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    check("t4_done", done, 1);
    check("t4_timeout", timeout, 0);
    check("t4_rc", run_cycles, 9);
    check("t4_cpu_rst", cpu_rst, 0);

    // 5: gapped input with start pulses during LOAD and valid/start during RUN
    start = 1'b1; load_len = 3; run_limit = 0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; load_len = 5; run_limit = 3; in_valid = 1'b0;
      tick();
      check("t5_gap_we_a", ram_we, 0);
      tick();
      check("t5_gap_we_b", ram_we, 0);
      start = 1'b0;
      in_valid = 1'b1; in_data = 8'(8'hC0 + i);
      tick();
      in_valid = 1'b0;
      check("t5_we", ram_we, 1);
      check("t5_addr", ram_addr, i);
      check("t5_data", ram_wdata, 32'(8'hC0 + i));
    end
    check("t5_in_run", cpu_rst, 0);
    in_valid = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_run_no_we", ram_we, 0);
      check("t5_run_busy", busy, 1);
      check("t5_run_ready", in_ready, 0);
    end
    in_valid = 1'b0; start = 1'b0;
    repeat (2) tick();
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    check("t5_done", done, 1);
    check("t5_timeout", timeout, 0);
    check("t5_rc", run_cycles, 5);

    // 6: out-of-range lengths are ignored
    start = 1'b1; load_len = 0;
    tick();
    start = 1'b0;
    check("t6_len0_busy", busy, 0);
    check("t6_len0_done", done, 1);
    start = 1'b1; load_len = 17;
    tick();
    start = 1'b0;
    check("t6_len17_busy", busy, 0);
    check("t6_len17_ready", in_ready, 0);
    check("t6_len17_done", done, 1);

    // 7: asynchronous reset mid-LOAD, then reload from address 0
    start = 1'b1; load_len = 4; run_limit = 0;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'hD1;
    tick();
    in_data = 8'hD2;
    tick();
    check("t7_pre_addr", ram_addr, 1);
    in_data = 8'hD3;
    #2 wb_rst_i = 1'b1;
    #1;
    check("t7_rst_ready", in_ready, 0);
    check("t7_rst_we", ram_we, 0);
    check("t7_rst_addr", ram_addr, 0);
    check("t7_rst_data", ram_wdata, 0);
    check("t7_rst_cpu_rst", cpu_rst, 1);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_done", done, 0);
    check("t7_rst_rc", run_cycles, 0);
    in_valid = 1'b0;
    tick();
    wb_rst_i = 1'b0;
    start = 1'b1; load_len = 0;
    tick();
    start = 1'b0;
    check("t7_len0_busy", busy, 0);
    check("t7_len0_ready", in_ready, 0);
    check("t7_len0_cpu_rst", cpu_rst, 1);
    start = 1'b1; load_len = 2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hE1 + i);
      tick();
      check("t7_we", ram_we, 1);
      check("t7_addr", ram_addr, i);
      check("t7_data", ram_wdata, 32'(8'hE1 + i));
    end
    in_valid = 1'b0;
    check("t7_run_cpu_rst", cpu_rst, 0);
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    check("t7_done", done, 1);
    check("t7_rc", run_cycles, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simplecpu_load_ctrl.md
Name: simplecpu_load_ctrl

Overview:
Sequencer that owns the simple CPU's program RAM and run control inside the user project.
- Accepts a program image as a stream of words from the host side (LA or a Wishbone shim) and writes it into RAM at ascending addresses.
- Holds the CPU in reset while loading, then releases it and counts cycles until the CPU halts or a watchdog limit expires.
- Reports status, including a cycle count, back to the host for firmware or bench checking.

Parameters:
ADDR_W, 4, program RAM address width (depth 2**ADDR_W words)
DATA_W, 8, RAM word width
CNT_W, 16, width of run-cycle counter and watchdog limit

Ports:
wb_clk_i  input  1  single clock for the block
wb_rst_i  input  1  asynchronous, active-high reset
start  input  1  pulse: begin a load/run session (ignored unless IDLE or FINISHED)
load_len  input  ADDR_W+1  number of words to load, 1..2**ADDR_W; sampled on accepted start
run_limit  input  CNT_W  watchdog limit in cycles; sampled on accepted start; 0 = no watchdog
in_valid  input  1  host word valid
in_data  input  DATA_W  host word
in_ready  output  1  block can accept a word this cycle
ram_we  output  1  RAM write strobe
ram_addr  output  ADDR_W  RAM write address
ram_wdata  output  DATA_W  RAM write data
cpu_rst  output  1  active-high reset to the CPU
cpu_halt  input  1  CPU halted flag (level)
busy  output  1  session in progress (LOAD or RUN)
done  output  1  CPU halted normally; held until the next accepted start
timeout  output  1  watchdog expired; held until the next accepted start
run_cycles  output  CNT_W  cycles spent in RUN, frozen on exit

Behaviour:
- Reset values (async, any time): state=IDLE, in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_rst=1, busy=0, done=0, timeout=0, run_cycles=0, internal word count=0.
- States: IDLE, LOAD, RUN, FINISHED.
- IDLE: cpu_rst=1.
  - start=1 with load_len in 1..2**ADDR_W: latch load_len and run_limit, clear done/timeout/run_cycles/word count, go to LOAD.
  - start with load_len=0 or load_len>2**ADDR_W: ignored; stay in IDLE.
- LOAD: cpu_rst=1, busy=1, in_ready=1 (combinational from state).
  - Transfer occurs when in_valid&&in_ready.
  - Next cycle (registered, 1-cycle latency): ram_we=1, ram_addr=word count, ram_wdata=in_data. Word count then increments.
  - ram_we is a single-cycle pulse per transfer. Back-to-back transfers give one write per cycle.
  - In the cycle the final word (count==load_len-1) is accepted: in_ready drops the next cycle, the final write is issued, and the state goes to RUN in that same cycle.
  - Address wraps only at 2**ADDR_W, which load_len validation makes unreachable.
- RUN: cpu_rst=0 from the first RUN cycle, busy=1, in_ready=0. run_cycles increments every RUN cycle; it saturates at all-ones and does not wrap.
  - cpu_halt=1: go to FINISHED with done=1. The halting cycle is not counted.
  - run_limit!=0 and run_cycles==run_limit-1 in the current cycle: go to FINISHED with timeout=1 and cpu_rst=1.
  - Halt and limit in the same cycle: halt wins. done=1, timeout=0.
- FINISHED: busy=0.
  - cpu_rst stays 0 after done, so the halted CPU state remains visible. cpu_rst=1 after timeout.
  - An accepted start behaves as in IDLE: it begins a new session and asserts cpu_rst=1 on the next cycle.
- start while busy: ignored, with no effect on counters or latched values.
- in_valid outside LOAD: ignored; no RAM write.
- Reset mid-LOAD or mid-RUN: immediate return to reset values. Partial RAM contents are not cleared.
- cpu_halt during LOAD: ignored, since the CPU is in reset.

Test Plan:
- Reset, then start with load_len=4 and 4 back-to-back words 0x11,0x22,0x33,0x44 -> ram_we pulses at addr 0..3 with matching data on the 4 cycles after each accept. in_ready drops after the 4th accept. cpu_rst falls on the first RUN cycle.
- Load 16 words, then cpu_halt asserted 37 cycles after RUN entry -> done=1, timeout=0, run_cycles=37, cpu_rst stays 0, busy=0.
- run_limit=10 and cpu_halt never asserted -> timeout=1 after exactly 10 RUN cycles, run_cycles=10, cpu_rst=1.
- run_limit=10 with cpu_halt rising in the 10th RUN cycle -> done=1, timeout=0.
- Gapped in_valid (valid every 3rd cycle) with load_len=3, plus start pulses during LOAD, plus in_valid pulses during RUN -> exactly 3 writes at addr 0,1,2; no restart; no extra writes.
- start with load_len=0 -> stays IDLE. Assert wb_rst_i mid-LOAD after 2 words -> all outputs return to reset values asynchronously. A new start then loads from addr 0 again.
